bias_accumulate_stage: RTL and testbench
========================================

# bias_accumulate_stage

Consumes the per-lane partial sums from the adder tree over `N_TILES` input-channel tiles and adds the per-lane constant bias vector supplied by the layer's `BIAS_layer*` block. It then saturates each lane to the 18-bit activation format, optionally applies ReLU, and presents one registered output vector per output pixel. It sits directly downstream of the adder tree and bias constant block, and upstream of the activation write-back.

## Interface
- `N_adder_tree`, default 16: number of parallel lanes.
- `DATA_W`, default 18: width of partial sums, bias and output per lane (signed two's complement, same fixed-point scale).
- `ACC_W`, default 24: internal accumulator width per lane; must be at least `DATA_W`+2.
- `N_TILES`, default 4: partial-sum beats accumulated per output vector; must be at least 1.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `psum_in`, in, `N_adder_tree*DATA_W`: lane i occupies bits `[DATA_W*(i+1)-1 : DATA_W*i]`.
- `psum_valid`, in, 1: a `psum_in` beat is offered.
- `psum_ready`, out, 1: the beat is accepted when `psum_valid` and `psum_ready` are both 1.
- `bias_in`, in, `N_adder_tree*DATA_W`: constant bias vector with the same lane packing; sampled only on the final tile beat.
- `act_out`, out, `N_adder_tree*DATA_W`: registered result with the same lane packing.
- `act_valid`, out, 1: `act_out` holds a result.
- `act_ready`, in, 1: downstream accepts the result.
- `sat_flag`, out, 1: 1 alongside `act_valid` if any lane of the current result saturated.

## Operation
- The FSM has two states.
  - ACC: collecting beats.
  - FULL: the output register is occupied.
- `tile_cnt` runs from 0 to `N_TILES`-1.
- On an accepted beat with `tile_cnt` below `N_TILES`-1:
  - For each lane, `acc[i]` is set to `acc[i]` plus sign-extended `psum[i]`; when `tile_cnt`=0 the old `acc` value is treated as 0.
  - The running `acc` saturates at the `ACC_W` signed bounds.
  - `tile_cnt` increments.
- On an accepted beat with `tile_cnt`=`N_TILES`-1:
  - For each lane, `sum` = `acc` + `psum` + sign-extended `bias`, computed at `ACC_W`+1 bits.
  - `sum` is saturated to the range [-2^(`DATA_W`-1), 2^(`DATA_W`-1)-1] and loaded into `act_out`.
  - `sat_flag` is loaded with the OR of the per-lane saturation events, covering both accumulator and output saturation.
  - `tile_cnt` goes to 0, `act_valid` goes to 1, and the state goes to FULL.
- `psum_ready` = (state==ACC) OR `act_ready`.
- In FULL with `act_ready`=1, the output drains.
  - If a beat is also accepted in that cycle, it is processed as above in the same cycle.
  - If that beat is the final beat (`N_TILES`=1), new data is loaded and the state stays FULL with `act_valid` held at 1.
  - Otherwise the state returns to ACC.
- In FULL with `act_ready`=0: `psum_ready`=0 and `act_out`, `act_valid` and `sat_flag` are held stable.
- Reset, including mid-tile: `tile_cnt`=0, `acc`=0, state=ACC, `act_out`=0, `act_valid`=0, `sat_flag`=0; any partial accumulation is discarded.

## Timing
- Final beat accepted at cycle t: `act_valid`=1 at t+1.
- Throughput: one beat per cycle while `act_ready` stays 1; one output every `N_TILES` cycles.
- No combinational path from `psum_in` or `bias_in` to any output.
- `psum_ready` depends combinationally on `act_ready` and state only.
- `psum_valid`=0 in any state: no state change except an output drain.

## Configuration
- `BIAS_ACC_RELU_EN` defined: after saturation, a negative lane result is replaced by 0.
  - ReLU never sets `sat_flag`.
- Not defined: the saturated signed result passes unchanged.

## Structure
- Shared package holds:
  - `ACC_W` default.
  - The DATA_W saturation bounds as localparams.
  - The FSM state enum (ACC, FULL).
  - A `sat_signed` function (width-parameterised clamp).
- One sub-module, `bias_lane_acc`: a single lane's accumulator, final add and saturate, instantiated `N_adder_tree` times by generate.
- The top level holds the FSM, `tile_cnt`, handshake and output register.

## Test plan
- Lane 0, `bias`=5020, psums 100, 200, 300, 400 over 4 beats -> `act_out` lane 0 = 6020, `act_valid` at final beat +1, `sat_flag`=0.
- Lane 1, `bias`=-76, psums -10 × 4 -> -116 without `BIAS_ACC_RELU_EN`; 0 with it; `sat_flag`=0 in both builds.
- Lane 2, psums 131071 × 4, `bias`=0 -> `act_out`=131071, `sat_flag`=1; psums -131072 × 4 -> -131072, `sat_flag`=1.
- Hold `act_ready`=0 for 5 cycles after the output -> `psum_ready`=0, `act_out` stable. Then raise `act_ready` with `psum_valid`=1 -> drain and beat 0 accepted in the same cycle.
- Assert `rst_n`=0 after beat 2 -> all outputs 0. Then a fresh 4-beat sequence -> result excludes the pre-reset beats.
- `N_TILES`=1, `psum_valid` and `act_ready` held at 1 -> one result per cycle, `act_valid` continuously 1.

Source files
------------

// File: rtl/bias_accumulate_stage_pkg.sv
// Shared definitions for the bias/accumulate stage: default widths, activation
// saturation bounds, FSM state encoding and a generic signed clamp helper.
package bias_accumulate_stage_pkg;

  localparam int BAS_ACC_W  = 24;
  localparam int BAS_DATA_W = 18;

  // Activation format limits for the default DATA_W.
  localparam logic signed [BAS_DATA_W-1:0] BAS_DATA_MAX = {1'b0, {(BAS_DATA_W-1){1'b1}}};
  localparam logic signed [BAS_DATA_W-1:0] BAS_DATA_MIN = {1'b1, {(BAS_DATA_W-1){1'b0}}};

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Clamp a 64-bit signed value into the signed range of a w-bit word.
  // The result stays 64 bits wide so callers can compare it against the input
  // to detect that clamping happened.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/bias_accumulate_stage_lane.sv
// Single-lane accumulator: running sum over tiles with ACC_W saturation, then
// final add of the bias and clamp to the activation format.
// Optional feature macro: BIAS_ACC_RELU_EN (clamp negative results to zero).
module bias_lane_acc
  import bias_accumulate_stage_pkg::*;
#(
  parameter int DATA_W = BAS_DATA_W,
  parameter int ACC_W  = BAS_ACC_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              accept_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] psum_i,
  input  logic [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0] res_o,
  output logic              sat_o
);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     acc_sat_q, acc_sat_d;
  logic signed [ACC_W-1:0]  base;
  logic                     base_sat;
  logic signed [ACC_W:0]    sum_run;
  logic signed [ACC_W:0]    sum_fin;
  logic signed [63:0]       run_wide, run_clamp;
  logic signed [63:0]       fin_wide, fin_clamp;
  logic                     out_sat;
  logic signed [DATA_W-1:0] res_sat;

  // Running sum and final result; the first tile ignores whatever acc holds.
  always_comb begin
    base      = first_i ? '0 : acc_q;
    base_sat  = first_i ? 1'b0 : acc_sat_q;
    sum_run   = {base[ACC_W-1], base} + {{(ACC_W+1-DATA_W){psum_i[DATA_W-1]}}, psum_i};
    sum_fin   = sum_run + {{(ACC_W+1-DATA_W){bias_i[DATA_W-1]}}, bias_i};
    run_wide  = {{(63-ACC_W){sum_run[ACC_W]}}, sum_run};
    fin_wide  = {{(63-ACC_W){sum_fin[ACC_W]}}, sum_fin};
    run_clamp = sat_signed(run_wide, ACC_W);
    fin_clamp = sat_signed(fin_wide, DATA_W);
    acc_d     = run_clamp[ACC_W-1:0];
    acc_sat_d = base_sat | (run_clamp != run_wide);
    out_sat   = (fin_clamp != fin_wide);
    res_sat   = fin_clamp[DATA_W-1:0];
`ifdef BIAS_ACC_RELU_EN
    res_o     = res_sat[DATA_W-1] ? '0 : res_sat;
`else
    res_o     = res_sat;
`endif
    // ReLU is applied after this flag is formed, so it never contributes.
    sat_o     = base_sat | out_sat;
  end

  // Accumulator only advances on non-final beats; the final beat feeds the
  // output register directly and the next first beat restarts from zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
    end else if (accept_i && !last_i) begin
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
    end
  end

endmodule

// File: rtl/bias_accumulate_stage.sv
// Bias/accumulate stage top: tile counter, ACC/FULL handshake FSM and the
// registered output vector. Lanes are bias_lane_acc instances.
// Optional feature macro: BIAS_ACC_RELU_EN (handled inside each lane).
//
// state   | meaning
// ST_ACC  | collecting partial-sum beats, output register empty
// ST_FULL | output register holds a result awaiting act_ready
module bias_accumulate_stage
  import bias_accumulate_stage_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int DATA_W       = BAS_DATA_W,
  parameter int ACC_W        = BAS_ACC_W,
  parameter int N_TILES      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_adder_tree*DATA_W-1:0] psum_in,
  input  logic                           psum_valid,
  output logic                           psum_ready,
  input  logic [N_adder_tree*DATA_W-1:0] bias_in,
  output logic [N_adder_tree*DATA_W-1:0] act_out,
  output logic                           act_valid,
  input  logic                           act_ready,
  output logic                           sat_flag
);

  localparam int CNT_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TILES - 1);

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 tile_cnt_q, tile_cnt_d;
  logic [N_adder_tree*DATA_W-1:0]   act_q;
  logic                             sat_q;
  logic                             accept;
  logic                             first_beat;
  logic                             last_beat;
  logic [N_adder_tree*DATA_W-1:0]   lane_res;
  logic [N_adder_tree-1:0]          lane_sat;

  // A drain and a new beat may share a cycle, so ready looks only at act_ready.
  assign psum_ready = (state_q == ST_ACC) || act_ready;
  assign accept     = psum_valid && psum_ready;
  assign first_beat = (tile_cnt_q == '0);
  assign last_beat  = (tile_cnt_q == LAST_CNT);

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_lane_acc #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .accept_i (accept),
      .first_i  (first_beat),
      .last_i   (last_beat),
      .psum_i   (psum_in[DATA_W*i +: DATA_W]),
      .bias_i   (bias_in[DATA_W*i +: DATA_W]),
      .res_o    (lane_res[DATA_W*i +: DATA_W]),
      .sat_o    (lane_sat[i])
    );
  end

  // Next tile count and FSM state; a final beat always (re)fills the output.
  always_comb begin
    tile_cnt_d = tile_cnt_q;
    state_d    = state_q;
    if (accept)
      tile_cnt_d = last_beat ? '0 : tile_cnt_q + 1'b1;
    if (accept && last_beat)
      state_d = ST_FULL;
    else if ((state_q == ST_FULL) && act_ready)
      state_d = ST_ACC;
  end

  // State, counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      tile_cnt_q <= '0;
      act_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_cnt_q <= tile_cnt_d;
      if (accept && last_beat) begin
        act_q <= lane_res;
        sat_q <= |lane_sat;
      end
    end
  end

  assign act_out   = act_q;
  assign act_valid = (state_q == ST_FULL);
  assign sat_flag  = sat_q && (state_q == ST_FULL);

endmodule

// File: tb/tb_bias_accumulate_stage.sv
module tb_bias_accumulate_stage;
  import bias_accumulate_stage_pkg::*;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int W  = N * DW;
`ifdef BIAS_ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] act;
    logic         sat;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] psum_in, bias_in, act_out;
  logic         psum_valid, psum_ready, act_valid, act_ready, sat_flag;
  logic [W-1:0] psum1_in, bias1_in, act1_out;
  logic         psum1_valid, psum1_ready, act1_valid, act1_ready, sat1_flag;

  int n_cmp = 0;
  int n_err = 0;

  bias_accumulate_stage #(.N_adder_tree(N), .DATA_W(DW), .ACC_W(24), .N_TILES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .bias_in(bias_in), .act_out(act_out),
    .act_valid(act_valid), .act_ready(act_ready), .sat_flag(sat_flag));

  bias_accumulate_stage #(.N_adder_tree(N), .DATA_W(DW), .ACC_W(24), .N_TILES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .psum_in(psum1_in), .psum_valid(psum1_valid),
    .psum_ready(psum1_ready), .bias_in(bias1_in), .act_out(act1_out),
    .act_valid(act1_valid), .act_ready(act1_ready), .sat_flag(sat1_flag));

  function automatic logic [W-1:0] vec4(int a, int b, int c, int d);
    logic [W-1:0] v;
    v = '0;
    v[0*DW +: DW] = a[DW-1:0];
    v[1*DW +: DW] = b[DW-1:0];
    v[2*DW +: DW] = c[DW-1:0];
    v[3*DW +: DW] = d[DW-1:0];
    return v;
  endfunction

  function automatic int relu(int x);
    if (RELU && x < 0) return 0;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitors: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && act_valid && act_ready) begin
      if (q4.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL u4_unexpected_output: got %h expected none", act_out);
      end else begin
        e4 = q4.pop_front();
        chk("u4_act_out", act_out, e4.act);
        chk("u4_sat_flag", W'(sat_flag), W'(e4.sat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && act1_valid && act1_ready) begin
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL u1_unexpected_output: got %h expected none", act1_out);
      end else begin
        e1 = q1.pop_front();
        chk("u1_act_out", act1_out, e1.act);
        chk("u1_sat_flag", W'(sat1_flag), W'(e1.sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [W-1:0] p, input logic [W-1:0] b, input bit is_last);
    int n;
    n = 0;
    psum_in = p; bias_in = b; psum_valid = 1'b1;
    #1;
    while (!psum_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL beat_timeout: psum_ready stayed 0 required 1");
    end
    @(posedge clk); #1;
    psum_valid = 1'b0;
    if (is_last) chk("act_valid_latency", W'(act_valid), W'(1));
  endtask

  task automatic send_vec4(input logic [W-1:0] p0, input logic [W-1:0] p1,
                           input logic [W-1:0] p2, input logic [W-1:0] p3,
                           input logic [W-1:0] b, input logic [W-1:0] e_act, input logic e_sat);
    exp_t t;
    t.act = e_act; t.sat = e_sat;
    q4.push_back(t);
    send_beat(p0, b, 1'b0);
    send_beat(p1, b, 1'b0);
    send_beat(p2, b, 1'b0);
    send_beat(p3, b, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t t;
    psum_in = '0; bias_in = '0; psum_valid = 1'b0; act_ready = 1'b1;
    psum1_in = '0; bias1_in = '0; psum1_valid = 1'b0; act1_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_act_valid", W'(act_valid), W'(0));
    chk("reset_act_out", act_out, '0);
    chk("reset_sat_flag", W'(sat_flag), W'(0));
    chk("reset_psum_ready", W'(psum_ready), W'(1));
    rst_n = 1'b1;
    tick();

    // Lane 0 bias add, lane 1 negative sum.
    send_vec4(vec4(100, -10, 0, 0), vec4(200, -10, 0, 0), vec4(300, -10, 0, 0),
              vec4(400, -10, 0, 0), vec4(5020, -76, 0, 0),
              vec4(6020, relu(-116), 0, 0), 1'b0);
    // Lane 2 positive and negative output saturation.
    send_vec4(vec4(0, 0, 131071, 0), vec4(0, 0, 131071, 0), vec4(0, 0, 131071, 0),
              vec4(0, 0, 131071, 0), '0, vec4(0, 0, 131071, 0), 1'b1);
    send_vec4(vec4(0, 0, -131072, 0), vec4(0, 0, -131072, 0), vec4(0, 0, -131072, 0),
              vec4(0, 0, -131072, 0), '0, vec4(0, 0, relu(-131072), 0), 1'b1);
    tick();

    // Backpressure: result held for 5 cycles.
    act_ready = 1'b0;
    send_vec4(vec4(0, 0, 0, 1), vec4(0, 0, 0, 2), vec4(0, 0, 0, 3), vec4(0, 0, 0, 4),
              vec4(0, 0, 0, 10), vec4(0, 0, 0, 20), 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_psum_ready", W'(psum_ready), W'(0));
      chk("stall_act_valid", W'(act_valid), W'(1));
      chk("stall_act_out", act_out, vec4(0, 0, 0, 20));
      tick();
    end
    act_ready = 1'b1;
    #1;
    chk("drain_same_cycle_ready", W'(psum_ready), W'(1));
    send_vec4(vec4(-500, 7, 0, 0), vec4(-500, 7, 0, 0), vec4(-500, 7, 0, 0),
              vec4(-500, 7, 0, 0), vec4(0, 3, 0, 0),
              vec4(relu(-2000), 31, 0, 0), 1'b0);
    tick();

    // Reset mid-tile discards the partial accumulation.
    send_beat(vec4(1000, 0, 0, 0), '0, 1'b0);
    send_beat(vec4(1000, 0, 0, 0), '0, 1'b0);
    send_beat(vec4(1000, 0, 0, 0), '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_act_valid", W'(act_valid), W'(0));
    chk("midreset_act_out", act_out, '0);
    chk("midreset_sat_flag", W'(sat_flag), W'(0));
    chk("midreset_psum_ready", W'(psum_ready), W'(1));
    tick();
    rst_n = 1'b1;
    tick();
    send_vec4(vec4(1, 0, 0, 0), vec4(1, 0, 0, 0), vec4(1, 0, 0, 0), vec4(1, 0, 0, 0),
              '0, vec4(4, 0, 0, 0), 1'b0);
    tick();
    tick();

    // N_TILES=1: one result per cycle, act_valid held high.
    for (int k = 1; k <= 4; k++) begin
      psum1_in = vec4(10 * k, -k, 0, 0);
      bias1_in = vec4(1, 1, 0, 0);
      t.act = vec4(10 * k + 1, relu(1 - k), 0, 0);
      t.sat = 1'b0;
      q1.push_back(t);
      psum1_valid = 1'b1;
      tick();
      chk("u1_act_valid_continuous", W'(act1_valid), W'(1));
    end
    psum1_valid = 1'b0;
    tick();
    chk("u1_drained", W'(act1_valid), W'(0));
    tick();

    chk("u4_queue_empty", W'(q4.size()), '0);
    chk("u1_queue_empty", W'(q1.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
